// File: rtl/fir_mc_filter.sv
// Multi-channel FIR filter: one delay line per channel, shared coefficient set,
// single time-shared multiplier sequenced by an IDLE/MAC/ROUND/OUT FSM.
module fir_mc_filter #(
  parameter int WIDTH    = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  parameter int FRAC     = 12,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int KW      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic [CW-1:0]           in_chan,
  input  logic                    coeff_we,
  input  logic [KW-1:0]           coeff_addr,
  input  logic signed [WIDTH-1:0] coeff_data,
  output logic                    coeff_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CW-1:0]           out_chan,
  output logic                    out_sat
);

  localparam int ACCW = 2*WIDTH + $clog2(TAPS);
  localparam logic [KW:0]              TAPS_W = (KW+1)'(TAPS);
  localparam logic [KW-1:0]            LAST   = KW'(TAPS-1);
  localparam logic [CW-1:0]            CH_MAX = CW'(CHANNELS-1);
  localparam logic signed [WIDTH-1:0]  UNITY  = WIDTH'(1) << FRAC;
  localparam logic signed [ACCW-1:0]   HALF   = ACCW'(1) << (FRAC-1);
  localparam logic signed [ACCW-1:0]   MAXV   = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0]   MINV   = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;
  state_t state, state_nxt;

  logic signed [WIDTH-1:0]   coeff [TAPS];
  logic signed [WIDTH-1:0]   dl    [CHANNELS][TAPS];
  logic signed [ACCW-1:0]    acc;
  logic [KW-1:0]             tap;
  logic [CW-1:0]             cur_chan;

  logic                      xfer;
  logic                      coeff_ok;
  logic [CW-1:0]             chan_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]    rnd;
  logic signed [ACCW-1:0]    shifted;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign xfer      = in_valid && in_ready;
  // Writes only land while idle and not racing an input transfer, so the
  // coefficient set is frozen for the whole MAC of every accepted sample.
  assign coeff_ok  = (state == IDLE) && !xfer && ({1'b0, coeff_addr} < TAPS_W);
  assign chan_sel  = (in_chan >= CH_MAX) ? CH_MAX : in_chan;
  assign prod      = coeff[tap] * dl[cur_chan][tap];
  assign rnd       = acc + HALF;
  assign shifted   = rnd >>> FRAC;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (tap == LAST) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned k = 0; k < TAPS; k++)
          dl[c][k] <= '0;
      for (int unsigned k = 0; k < TAPS; k++)
        coeff[k] <= (k == 0) ? UNITY : '0;
      acc       <= '0;
      tap       <= '0;
      cur_chan  <= '0;
      coeff_err <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sat   <= 1'b0;
    end else begin
      coeff_err <= coeff_we && !coeff_ok;
      if (coeff_we && coeff_ok)
        coeff[coeff_addr] <= coeff_data;

      if (xfer) begin
        for (int unsigned k = TAPS-1; k > 0; k--)
          dl[chan_sel][k] <= dl[chan_sel][k-1];
        dl[chan_sel][0] <= in_data;
        acc      <= '0;
        tap      <= '0;
        cur_chan <= chan_sel;
      end

      if (state == MAC) begin
        acc <= acc + {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        tap <= tap + 1'b1;
      end

      if (state == ROUND) begin
        out_chan <= cur_chan;
        if (shifted > MAXV) begin
          out_data <= MAXV[WIDTH-1:0];
          out_sat  <= 1'b1;
        end else if (shifted < MINV) begin
          out_data <= MINV[WIDTH-1:0];
          out_sat  <= 1'b1;
        end else begin
          out_data <= shifted[WIDTH-1:0];
          out_sat  <= 1'b0;
        end
      end
    end
  end

endmodule
